// File: rtl/sha3_absorb_buffer_if.sv
// Lane, permutation and digest handshake bundle for the SHA-3 absorb buffer.
interface sha3_absorb_buffer_if #(
  parameter int unsigned LANE_W   = 64,
  parameter int unsigned STATE_W  = 1600,
  parameter int unsigned DIGEST_W = 512
);
  logic [LANE_W-1:0]   lane_in;
  logic                lane_valid;
  logic                lane_ready;
  logic                msg_last;
  logic [1:0]          mode;
  logic                perm_start;
  logic [STATE_W-1:0]  perm_state_out;
  logic                perm_done;
  logic [STATE_W-1:0]  perm_state_in;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                digest_ack;
  logic                busy;

  // Host / padder / permutation-core side.
  modport master (
    output lane_in, lane_valid, msg_last, mode, perm_done, perm_state_in, digest_ack,
    input  lane_ready, perm_start, perm_state_out, digest, digest_valid, busy
  );

  // Absorb buffer side.
  modport slave (
    input  lane_in, lane_valid, msg_last, mode, perm_done, perm_state_in, digest_ack,
    output lane_ready, perm_start, perm_state_out, digest, digest_valid, busy
  );
endinterface

// File: rtl/sha3_absorb_buffer.sv
// SHA-3 absorb buffer: XORs padded rate lanes into the Keccak state, hands each
// full block to the f-permutation core and presents the digest after the last block.
module sha3_absorb_buffer #(
  parameter int unsigned LANE_W   = 64,
  parameter int unsigned STATE_W  = 1600,
  parameter int unsigned DIGEST_W = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  sha3_absorb_buffer_if.slave  bus
);

  localparam int unsigned NUM_LANES = STATE_W / LANE_W;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PERM_START,
    PERM_WAIT,
    DONE
  } fsm_t;

  fsm_t               st, st_n;
  logic [STATE_W-1:0] state_q, state_n;
  logic [STATE_W-1:0] lane_xor;
  logic [4:0]         idx, idx_n;
  logic [4:0]         sel_idx;
  logic [4:0]         rate;
  logic               last_flag, last_n;
  logic [1:0]         mode_r, mode_n;
  logic               lane_ready;
  logic               accept;

  function automatic logic [4:0] rate_of(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd9;
      2'd2:    return 5'd21;
      default: return 5'd17;
    endcase
  endfunction

  assign lane_ready = (st == IDLE) || (st == ABSORB);
  assign accept     = bus.lane_valid && lane_ready;

  assign bus.lane_ready     = lane_ready;
  assign bus.perm_start     = (st == PERM_START);
  assign bus.perm_state_out = state_q;
  assign bus.digest         = state_q[DIGEST_W-1:0];
  assign bus.digest_valid   = (st == DONE);
  assign bus.busy           = (st != IDLE);

  // Rate and target lane: IDLE uses the live mode and lane 0, later lanes use the latched mode.
  always_comb begin
    rate     = rate_of((st == IDLE) ? bus.mode : mode_r);
    sel_idx  = (st == IDLE) ? '0 : idx;
    lane_xor = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (5'(k) == sel_idx) lane_xor[k*LANE_W +: LANE_W] = bus.lane_in;
    end
  end

  // Next-state logic for the FSM and the absorb datapath.
  always_comb begin
    st_n    = st;
    state_n = state_q;
    idx_n   = idx;
    last_n  = last_flag;
    mode_n  = mode_r;
    case (st)
      IDLE: begin
        if (accept) begin
          mode_n  = bus.mode;
          state_n = state_q ^ lane_xor;
          last_n  = bus.msg_last;
          if (rate == 5'd1) begin
            idx_n = '0;
            st_n  = PERM_START;
          end else begin
            idx_n = 5'd1;
            st_n  = ABSORB;
          end
        end
      end
      ABSORB: begin
        if (accept) begin
          state_n = state_q ^ lane_xor;
          last_n  = last_flag | bus.msg_last;
          if (idx == rate - 5'd1) begin
            idx_n = '0;
            st_n  = PERM_START;
          end else begin
            idx_n = idx + 5'd1;
          end
        end
      end
      PERM_START: begin
        st_n = PERM_WAIT;
      end
      PERM_WAIT: begin
        if (bus.perm_done) begin
          state_n = bus.perm_state_in;
          if (last_flag) begin
            st_n = DONE;
          end else begin
            st_n   = ABSORB;
            idx_n  = '0;
            last_n = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.digest_ack) begin
          state_n = '0;
          last_n  = 1'b0;
          st_n    = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // State register, lane index, sticky last flag and latched mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      state_q   <= '0;
      idx       <= '0;
      last_flag <= 1'b0;
      mode_r    <= '0;
    end else begin
      st        <= st_n;
      state_q   <= state_n;
      idx       <= idx_n;
      last_flag <= last_n;
      mode_r    <= mode_n;
    end
  end

endmodule

// File: tb/tb_sha3_absorb_buffer.sv
// Bench for sha3_absorb_buffer: directed messages, a lane-array reference model
// checked every cycle, and literal expectations for the listed scenarios.
module tb_sha3_absorb_buffer;

  localparam int unsigned LW = 64;
  localparam int unsigned SW = 1600;
  localparam int unsigned DW = 512;
  localparam int unsigned NL = 25;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  sha3_absorb_buffer_if #(.LANE_W(LW), .STATE_W(SW), .DIGEST_W(DW)) bus ();

  sha3_absorb_buffer #(.LANE_W(LW), .STATE_W(SW), .DIGEST_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [LW-1:0] m_lanes [NL];
  int unsigned   m_cnt    = 0;
  int unsigned   m_rate   = 0;
  bit            m_active = 1'b0;
  bit            m_last   = 1'b0;
  bit            m_pulse  = 1'b0;
  bit            m_wait   = 1'b0;
  bit            m_done   = 1'b0;

  function automatic logic [SW-1:0] model_state();
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < NL; k++) r[k*LW +: LW] = m_lanes[k];
    return r;
  endfunction

  function automatic int unsigned rate_for(input logic [1:0] m);
    int unsigned tbl [4] = '{9, 17, 21, 17};
    return tbl[m];
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int unsigned r, c;
    bit first;
    if (rst) begin
      for (int k = 0; k < NL; k++) m_lanes[k] <= '0;
      m_cnt <= 0; m_rate <= 0; m_active <= 1'b0; m_last <= 1'b0;
      m_pulse <= 1'b0; m_wait <= 1'b0; m_done <= 1'b0;
    end else if (m_done) begin
      if (bus.digest_ack) begin
        for (int k = 0; k < NL; k++) m_lanes[k] <= '0;
        m_done <= 1'b0; m_active <= 1'b0; m_last <= 1'b0;
      end
    end else if (m_pulse) begin
      m_pulse <= 1'b0;
      m_wait  <= 1'b1;
    end else if (m_wait) begin
      if (bus.perm_done) begin
        for (int k = 0; k < NL; k++) m_lanes[k] <= bus.perm_state_in[k*LW +: LW];
        m_wait <= 1'b0;
        if (m_last) m_done <= 1'b1;
        else        m_last <= 1'b0;
      end
    end else if (bus.lane_valid) begin
      first = !m_active;
      r     = first ? rate_for(bus.mode) : m_rate;
      c     = first ? 0 : m_cnt;
      m_lanes[c] <= m_lanes[c] ^ bus.lane_in;
      m_last     <= (first ? 1'b0 : m_last) | bus.msg_last;
      m_active   <= 1'b1;
      m_rate     <= r;
      if (c + 1 == r) begin
        m_cnt   <= 0;
        m_pulse <= 1'b1;
      end else begin
        m_cnt <= c + 1;
      end
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk64(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    int bad;
    checks++;
    if (got !== exp) begin
      errors++;
      bad = 0;
      for (int k = NL - 1; k >= 0; k--) if (got[k*LW +: LW] !== exp[k*LW +: LW]) bad = k;
      $display("FAIL %s: lane %0d got %h expected %h at %0t", nm, bad,
               got[bad*LW +: LW], exp[bad*LW +: LW], $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : compare
    logic [SW-1:0] ms;
    ms = model_state();
    chk1("lane_ready", bus.lane_ready, !(m_pulse || m_wait || m_done));
    chk1("busy", bus.busy, m_active);
    chk1("perm_start", bus.perm_start, m_pulse);
    chk1("digest_valid", bus.digest_valid, m_done);
    chk_wide("state", bus.perm_state_out, ms);
    if (m_done) chk_wide("digest", {1088'd0, bus.digest}, {1088'd0, ms[DW-1:0]});
    if (bus.perm_start) pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lane(input logic [LW-1:0] v, input logic last, input logic [1:0] md);
    bit got;
    got            = 1'b0;
    bus.lane_in    = v;
    bus.msg_last   = last;
    bus.mode       = md;
    bus.lane_valid = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (bus.lane_ready) got = 1'b1;
      step();
    end
    bus.lane_valid = 1'b0;
    bus.msg_last   = 1'b0;
    chk1("lane_accepted_in_time", got, 1'b1);
  endtask

  // Mock permutation core: waits for the start pulse, idles in PERM_WAIT, returns a state.
  task automatic do_perm(input int unsigned wait_cycles, input bit ones);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus.perm_start) got = 1'b1;
    end
    chk1("perm_start_seen", got, 1'b1);
    if (got) begin
      chk1("perm_phase_ready", bus.lane_ready, 1'b0);
      step();
      repeat (wait_cycles) step();
      bus.perm_state_in = ones ? '1 : model_state();
      bus.perm_done     = 1'b1;
      step();
      bus.perm_done     = 1'b0;
    end
  endtask

  task automatic ack_digest();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus.digest_valid) got = 1'b1;
    end
    chk1("digest_valid_seen", got, 1'b1);
    step();
    bus.digest_ack = 1'b1;
    step();
    bus.digest_ack = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    logic [SW-1:0] expw;
    int p;
    rst               = 1'b1;
    bus.lane_in       = '0;
    bus.lane_valid    = 1'b0;
    bus.msg_last      = 1'b0;
    bus.mode          = 2'd0;
    bus.perm_done     = 1'b0;
    bus.perm_state_in = '0;
    bus.digest_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    chk1("rst_lane_ready", bus.lane_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_perm_start", bus.perm_start, 1'b0);
    chk1("rst_digest_valid", bus.digest_valid, 1'b0);
    chk_wide("rst_state", bus.perm_state_out, '0);

    // mode 1: 17 lanes of 1, last on lane 16, permutation returns all-ones.
    for (int k = 0; k < 17; k++) send_lane(64'h1, k == 16, 2'd1);
    chk1("t1_perm_start_after_lane16", bus.perm_start, 1'b1);
    expw = '0;
    for (int k = 0; k < 17; k++) expw[k*LW +: LW] = 64'h1;
    chk_wide("t1_xored_state", bus.perm_state_out, expw);
    do_perm(3, 1'b1);
    chk1("t1_digest_valid", bus.digest_valid, 1'b1);
    chk_wide("t1_digest", {1088'd0, bus.digest}, {1088'd0, {DW{1'b1}}});
    ack_digest();
    chk64("t1_pulses", 64'(pulses), 64'd1);

    // mode 0: two blocks of lane k = k+1, identity permutation, digest cancels to 0.
    p = pulses;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 9; k++) send_lane(64'(k + 1), (b == 1) && (k == 8), 2'd0);
      do_perm(2, 1'b0);
      if (b == 0) begin
        chk64("t2_blk1_lane3", bus.perm_state_out[3*LW +: LW], 64'd4);
        chk64("t2_blk1_lane9", bus.perm_state_out[9*LW +: LW], 64'd0);
      end
    end
    chk1("t2_digest_valid", bus.digest_valid, 1'b1);
    chk_wide("t2_digest_zero", {1088'd0, bus.digest}, '0);
    ack_digest();
    chk64("t2_pulses", 64'(pulses - p), 64'd2);

    // mode 2 with mode switched to 0 after lane 3: block stays 21 lanes.
    p = pulses;
    for (int k = 0; k < 21; k++) begin
      send_lane(64'hA5A5_0000_0000_0000 | 64'(k), k == 20, (k < 3) ? 2'd2 : 2'd0);
      if (k == 19) chk64("t3_no_early_pulse", 64'(pulses - p), 64'd0);
    end
    chk1("t3_perm_start_after_lane20", bus.perm_start, 1'b1);
    do_perm(1, 1'b0);
    chk64("t3_digest_lane0", bus.digest[63:0], 64'hA5A5_0000_0000_0000);
    chk64("t3_digest_lane7", bus.digest[7*LW +: LW], 64'hA5A5_0000_0000_0007);
    ack_digest();
    chk64("t3_pulses", 64'(pulses - p), 64'd1);

    // lane_valid held through a 10-cycle PERM_WAIT; early msg_last stays sticky.
    for (int k = 0; k < 9; k++) send_lane(64'h10 + 64'(k), 1'b0, 2'd0);
    bus.lane_in    = 64'hDEAD;
    bus.msg_last   = 1'b1;
    bus.lane_valid = 1'b1;
    do_perm(9, 1'b0);
    @(negedge clk);
    chk1("t4_ready_after_done", bus.lane_ready, 1'b1);
    step();
    bus.lane_valid = 1'b0;
    bus.msg_last   = 1'b0;
    chk64("t4_resume_lane0", bus.perm_state_out[63:0], 64'h10 ^ 64'hDEAD);
    chk64("t4_lane1_untouched", bus.perm_state_out[LW +: LW], 64'h11);
    p = pulses;
    for (int k = 1; k < 9; k++) send_lane(64'(k), 1'b0, 2'd0);
    do_perm(0, 1'b1);
    chk1("t4_sticky_last_done", bus.digest_valid, 1'b1);
    chk64("t4_pulses", 64'(pulses - p), 64'd1);

    // DONE held without ack, then ack together with a lane.
    repeat (3) begin
      step();
      chk_wide("t5_digest_hold", {1088'd0, bus.digest}, {1088'd0, {DW{1'b1}}});
    end
    bus.digest_ack = 1'b1;
    bus.lane_in    = 64'h0123_4567_89AB_CDEF;
    bus.mode       = 2'd0;
    bus.lane_valid = 1'b1;
    @(negedge clk);
    chk1("t5_no_accept_in_done", bus.lane_ready, 1'b0);
    step();
    bus.digest_ack = 1'b0;
    @(negedge clk);
    chk1("t5_ready_after_ack", bus.lane_ready, 1'b1);
    step();
    bus.lane_valid = 1'b0;
    chk_wide("t5_fresh_state", bus.perm_state_out, {1536'd0, 64'h0123_4567_89AB_CDEF});

    // Reset during PERM_WAIT, then a stale perm_done.
    for (int k = 1; k < 9; k++) send_lane(64'(k), 1'b0, 2'd0);
    chk1("t6_perm_start", bus.perm_start, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.perm_state_in = '1;
    bus.perm_done     = 1'b1;
    step();
    bus.perm_done     = 1'b0;
    step();
    chk_wide("t6_state_zero", bus.perm_state_out, '0);
    chk1("t6_idle", bus.busy, 1'b0);
    chk1("t6_perm_start", bus.perm_start, 1'b0);
    chk1("t6_digest_valid", bus.digest_valid, 1'b0);
    chk1("t6_lane_ready", bus.lane_ready, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
